// File: rtl/panic_prio_scheduler.sv
// Strict-priority, credit-based descriptor scheduler.
// Picks the highest-priority pending class and the next round-robin engine
// that has free buffer credit, then issues one tagged descriptor per load.
module panic_prio_scheduler #(
  parameter int CLASS_NUM       = 3,
  parameter int ENGINE_NUM      = 4,
  parameter int DEST_WIDTH      = 3,
  parameter int INIT_CREDIT_NUM = 2,
  parameter int CREDIT_WIDTH    = 4,
  parameter int DESC_WIDTH      = 32
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [CLASS_NUM*DESC_WIDTH-1:0]    s_desc_data,
  input  logic [CLASS_NUM-1:0]               s_desc_valid,
  output logic [CLASS_NUM-1:0]               s_desc_ready,
  output logic [DESC_WIDTH-1:0]              m_desc_data,
  output logic [DEST_WIDTH-1:0]              m_desc_dest,
  output logic [$clog2(CLASS_NUM)-1:0]       m_desc_class,
  output logic                               m_desc_valid,
  input  logic                               m_desc_ready,
  input  logic [ENGINE_NUM-1:0]              credit_return,
  input  logic [ENGINE_NUM-1:0]              engine_en,
  output logic [ENGINE_NUM*CREDIT_WIDTH-1:0] credit_count,
  output logic                               credit_err
);

  localparam int CLS_W = $clog2(CLASS_NUM);
  localparam int ENG_W = $clog2(ENGINE_NUM);
  localparam logic [CREDIT_WIDTH-1:0] CREDIT_MAX = CREDIT_WIDTH'(INIT_CREDIT_NUM);

  typedef enum logic {EMPTY, FULL} out_state_t;

  out_state_t                state;
  logic [CREDIT_WIDTH-1:0]   credit [ENGINE_NUM];
  logic [ENG_W-1:0]          rr_ptr;
  logic [ENGINE_NUM-1:0]     eligible;
  logic [ENGINE_NUM-1:0]     load_vec;
  logic [ENG_W-1:0]          eng_sel;
  logic [ENG_W-1:0]          cand;
  logic                      eng_found;
  logic [CLS_W-1:0]          cls_sel;
  logic                      cls_found;
  logic                      load_slot;
  logic                      load;

  assign m_desc_valid = (state == FULL);
  assign load_slot    = (state == EMPTY) || m_desc_ready;

  // Engine eligibility: enabled and holding at least one credit
  always_comb begin
    eligible = '0;
    for (int unsigned e = 0; e < ENGINE_NUM; e++)
      eligible[e] = engine_en[e] && (credit[e] != '0);
  end

  // Round-robin engine search starting just after the last picked engine;
  // ENGINE_NUM is a power of two so truncation gives the modulo wrap
  always_comb begin
    eng_found = 1'b0;
    eng_sel   = '0;
    cand      = '0;
    for (int unsigned k = 1; k <= ENGINE_NUM; k++) begin
      cand = rr_ptr + ENG_W'(k);
      if (!eng_found && eligible[cand]) begin
        eng_found = 1'b1;
        eng_sel   = cand;
      end
    end
  end

  // Strict priority class pick: lowest valid index wins
  always_comb begin
    cls_found = 1'b0;
    cls_sel   = '0;
    for (int unsigned i = 0; i < CLASS_NUM; i++) begin
      if (!cls_found && s_desc_valid[i]) begin
        cls_found = 1'b1;
        cls_sel   = CLS_W'(i);
      end
    end
  end

  // Load decision and per-class/per-engine handshake vectors
  always_comb begin
    load         = rst && load_slot && cls_found && eng_found;
    s_desc_ready = '0;
    load_vec     = '0;
    if (load) begin
      s_desc_ready[cls_sel] = 1'b1;
      load_vec[eng_sel]     = 1'b1;
    end
  end

  // Output register FSM, captured descriptor fields and round-robin pointer
  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= EMPTY;
      m_desc_data  <= '0;
      m_desc_dest  <= '0;
      m_desc_class <= '0;
      rr_ptr       <= ENG_W'(ENGINE_NUM - 1);
    end else begin
      case (state)
        EMPTY: if (load) state <= FULL;
        FULL:  if (m_desc_ready && !load) state <= EMPTY;
        default: state <= EMPTY;
      endcase
      if (load) begin
        m_desc_data  <= s_desc_data[int'(cls_sel)*DESC_WIDTH +: DESC_WIDTH];
        m_desc_dest  <= DEST_WIDTH'(eng_sel);
        m_desc_class <= cls_sel;
        rr_ptr       <= eng_sel;
      end
    end
  end

  // Per-engine credit counters; a return into a full counter is dropped and flagged
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned e = 0; e < ENGINE_NUM; e++)
        credit[e] <= CREDIT_MAX;
      credit_err <= 1'b0;
    end else begin
      for (int unsigned e = 0; e < ENGINE_NUM; e++) begin
        if (load_vec[e] && !credit_return[e]) begin
          credit[e] <= credit[e] - CREDIT_WIDTH'(1);
        end else if (credit_return[e] && !load_vec[e]) begin
          if (credit[e] == CREDIT_MAX)
            credit_err <= 1'b1;
          else
            credit[e] <= credit[e] + CREDIT_WIDTH'(1);
        end
      end
    end
  end

  // Flatten counters onto the status port
  always_comb begin
    credit_count = '0;
    for (int unsigned e = 0; e < ENGINE_NUM; e++)
      credit_count[e*CREDIT_WIDTH +: CREDIT_WIDTH] = credit[e];
  end

endmodule

// File: tb/tb_panic_prio_scheduler.sv
// Scoreboard bench for panic_prio_scheduler: a per-cycle reference model
// predicts handshakes and credits, a separate monitor checks issued descriptors.
module tb_panic_prio_scheduler;
  localparam int CN   = 3;
  localparam int EN   = 4;
  localparam int DW   = 3;
  localparam int INIT = 2;
  localparam int CW   = 4;
  localparam int DSW  = 32;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic [CN*DSW-1:0]   s_desc_data = '0;
  logic [CN-1:0]       s_desc_valid = '0;
  logic [CN-1:0]       s_desc_ready;
  logic [DSW-1:0]      m_desc_data;
  logic [DW-1:0]       m_desc_dest;
  logic [1:0]          m_desc_class;
  logic                m_desc_valid;
  logic                m_desc_ready = 1'b0;
  logic [EN-1:0]       credit_return = '0;
  logic [EN-1:0]       engine_en = '1;
  logic [EN*CW-1:0]    credit_count;
  logic                credit_err;

  always #5 clk = ~clk;

  panic_prio_scheduler #(
    .CLASS_NUM(CN), .ENGINE_NUM(EN), .DEST_WIDTH(DW),
    .INIT_CREDIT_NUM(INIT), .CREDIT_WIDTH(CW), .DESC_WIDTH(DSW)
  ) dut (
    .clk(clk), .rst(rst),
    .s_desc_data(s_desc_data), .s_desc_valid(s_desc_valid), .s_desc_ready(s_desc_ready),
    .m_desc_data(m_desc_data), .m_desc_dest(m_desc_dest), .m_desc_class(m_desc_class),
    .m_desc_valid(m_desc_valid), .m_desc_ready(m_desc_ready),
    .credit_return(credit_return), .engine_en(engine_en),
    .credit_count(credit_count), .credit_err(credit_err)
  );

  int n_chk  = 0;
  int n_fail = 0;

  logic [63:0] exp_q[$];
  int          dest_log[$];
  int          class_log[$];

  int m_cred[EN];
  int m_rr;
  bit m_full;
  bit m_err;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int e = 0; e < EN; e++) m_cred[e] = INIT;
    m_rr   = EN - 1;
    m_full = 1'b0;
    m_err  = 1'b0;
    exp_q.delete();
  endtask

  // Reference model evaluated once per cycle at the falling edge
  task automatic model_step();
    int cls;
    int eng;
    int c;
    bit load;
    logic [CN-1:0]    er;
    logic [EN*CW-1:0] cc;
    if (rst == 1'b0) begin
      chk("ready_in_reset", 64'(s_desc_ready), 64'(0));
      model_reset();
      return;
    end
    chk("m_desc_valid", 64'(m_desc_valid), 64'(m_full));
    cc = '0;
    for (int e = 0; e < EN; e++) cc[e*CW +: CW] = CW'(m_cred[e]);
    chk("credit_count", 64'(credit_count), 64'(cc));
    chk("credit_err", 64'(credit_err), 64'(m_err));

    cls = -1;
    for (int i = 0; i < CN; i++) if (cls < 0 && s_desc_valid[i]) cls = i;
    eng = -1;
    for (int k = 1; k <= EN; k++) begin
      c = (m_rr + k) % EN;
      if (eng < 0 && engine_en[c] && m_cred[c] > 0) eng = c;
    end
    load = (!m_full || m_desc_ready) && cls >= 0 && eng >= 0;

    er = '0;
    if (load) er[cls] = 1'b1;
    chk("s_desc_ready", 64'(s_desc_ready), 64'(er));

    if (load) begin
      exp_q.push_back(64'({s_desc_data[cls*DSW +: DSW], DW'(eng), 2'(cls)}));
      m_rr = eng;
    end
    for (int e = 0; e < EN; e++) begin
      int n;
      n = m_cred[e] + int'(credit_return[e]) - ((load && eng == e) ? 1 : 0);
      if (n > INIT) begin
        n = INIT;
        m_err = 1'b1;
      end
      m_cred[e] = n;
    end
    m_full = load ? 1'b1 : (m_desc_ready ? 1'b0 : m_full);
  endtask

  // Monitor: every presented descriptor must match the scoreboard head
  always @(negedge clk) begin
    if (rst === 1'b1 && m_desc_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL out_unexpected: got dest %0d class %0d expected no descriptor at %0t",
                 m_desc_dest, m_desc_class, $time);
      end else begin
        chk("out_desc", 64'({m_desc_data, m_desc_dest, m_desc_class}), exp_q[0]);
        if (m_desc_ready) begin
          void'(exp_q.pop_front());
          dest_log.push_back(int'(m_desc_dest));
          class_log.push_back(int'(m_desc_class));
        end
      end
    end
  end

  task automatic drive(input logic [CN-1:0] v, input logic mr,
                       input logic [EN-1:0] ret, input logic [EN-1:0] en);
    s_desc_valid  = v;
    m_desc_ready  = mr;
    credit_return = ret;
    engine_en     = en;
  endtask

  task automatic tick();
    for (int i = 0; i < CN; i++) s_desc_data[i*DSW +: DSW] = $urandom;
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    drive('0, 1'b0, '0, '1);
    tick();
    rst = 1'b1;
  endtask

  initial begin
    drive('0, 1'b0, '0, '1);
    tick();
    tick();
    rst = 1'b1;
    chk("reset_out_fields", 64'({m_desc_data, m_desc_dest, m_desc_class}), 64'(0));

    // Reset and priority: eight class-0 issues round-robin over all engines
    dest_log.delete();
    class_log.delete();
    drive(3'b111, 1'b1, '0, 4'hF);
    repeat (10) tick();
    chk("prio_count", 64'(dest_log.size()), 64'(8));
    for (int i = 0; i < 8; i++) begin
      chk("prio_dest", 64'((i < dest_log.size()) ? dest_log[i] : 99), 64'(i % 4));
      chk("prio_class", 64'((i < class_log.size()) ? class_log[i] : 99), 64'(0));
    end
    chk("credits_drained", 64'(credit_count), 64'(0));

    // Credit recycle on engine 2
    drive(3'b111, 1'b1, 4'b0100, 4'hF);
    tick();
    drive(3'b111, 1'b1, '0, 4'hF);
    repeat (3) tick();
    chk("recycle_count", 64'(dest_log.size()), 64'(9));
    chk("recycle_dest", 64'((dest_log.size() > 0) ? dest_log[$] : 99), 64'(2));
    chk("recycle_credits", 64'(credit_count), 64'(0));

    // Backpressure: only the first load consumes a credit
    do_reset();
    drive(3'b111, 1'b0, '0, 4'hF);
    repeat (6) tick();
    chk("bp_credits", 64'(credit_count), 64'(16'h2221));
    chk("bp_valid", 64'(m_desc_valid), 64'(1));

    // Enable mask with only class 2, then class 0 preempts
    do_reset();
    dest_log.delete();
    class_log.delete();
    drive(3'b100, 1'b1, '0, 4'b1010);
    repeat (6) tick();
    chk("mask_count", 64'(dest_log.size()), 64'(4));
    for (int i = 0; i < 4; i++) begin
      chk("mask_dest", 64'((i < dest_log.size()) ? dest_log[i] : 99), 64'((i % 2 == 0) ? 1 : 3));
      chk("mask_class", 64'((i < class_log.size()) ? class_log[i] : 99), 64'(2));
    end
    drive(3'b101, 1'b1, 4'b0010, 4'b1010);
    tick();
    drive(3'b101, 1'b1, '0, 4'b1010);
    repeat (3) tick();
    chk("preempt_class", 64'((class_log.size() > 0) ? class_log[$] : 99), 64'(0));
    chk("preempt_dest", 64'((dest_log.size() > 0) ? dest_log[$] : 99), 64'(1));

    // Simultaneous pick and return, then overflowing return
    do_reset();
    drive(3'b001, 1'b1, 4'b0001, 4'hF);
    tick();
    chk("same_cycle_credit0", 64'(credit_count[CW-1:0]), 64'(2));
    drive(3'b000, 1'b1, 4'b0010, 4'hF);
    tick();
    chk("overflow_err", 64'(credit_err), 64'(1));

    // Mid-operation reset while FULL
    do_reset();
    drive(3'b001, 1'b0, '0, 4'hF);
    tick();
    tick();
    chk("pre_reset_valid", 64'(m_desc_valid), 64'(1));
    rst = 1'b0;
    drive(3'b001, 1'b0, 4'b0001, 4'hF);
    tick();
    rst = 1'b1;
    chk("midreset_valid", 64'(m_desc_valid), 64'(0));
    chk("midreset_credits", 64'(credit_count), 64'(16'h2222));

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      logic [EN-1:0] ret;
      logic [EN-1:0] en;
      ret = '0;
      for (int e = 0; e < EN; e++) ret[e] = ($urandom_range(0, 5) == 0);
      en = ($urandom_range(0, 15) == 0) ? EN'($urandom) : engine_en;
      rst = ($urandom_range(0, 299) != 0);
      drive(CN'($urandom), ($urandom_range(0, 3) != 0), ret, en);
      tick();
    end
    rst = 1'b1;
    drive('0, 1'b1, '0, 4'hF);
    repeat (3) tick();
    chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
